mode_ctrl_fsm: RTL and testbench

Parametrised successor to the station's two-button front-panel controller. It has 2-flop synchronisers and tick-based debouncers on nMode and nStart, and an N-mode display state machine with wrap-around. Calibration entry requires a timed two-button hold, and per-mode counter clears require a long press, not a plain level. It sits between the panel buttons and the display mux / rain and elapsed-time counters, and runs off the 32.768 kHz Clock and the shared 1 ms tick.

---
 rtl/mode_ctrl_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_mode_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_ctrl_fsm.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mode_ctrl_fsm
//
// Front-panel controller for the two panel buttons. Each raw active-low button
// is passed through a 2-flop synchroniser and then a tick-based debouncer. The
// debounced levels drive an N-mode display state machine with wrap-around, a
// timed two-button hold that enters calibration, and a long-press-on-nStart
// clear that pulses one bit of nClear for the current mode.
//
// Optional feature (compile-time macro): AUTO_RETURN_EN
//   When defined, an inactivity counter returns the FSM to NORMAL(0) after
//   IDLE_TIMEOUT_MS ticks with no debounced button change and no state change.
//   When undefined, that counter does not exist and states persist.
//
// Ports:
//   Clock         in   32.768 kHz system clock
//   nReset        in   asynchronous active-low reset
//   tick_1kHz     in   one-Clock-cycle pulse every 1 ms
//   nMode         in   raw mode button, active-low, asynchronous
//   nStart        in   raw start button, active-low, asynchronous
//   display_mode  out  current mode index; NUM_MODES means calibration
//   in_calib      out  high while in calibration
//   nClear        out  one-hot active-low clear pulse, bit i clears mode i
//
// Handshake/timing: there is no valid/ready pair here. Every output is a
// register; a change of state or a clear pulse appears at the Clock edge that
// follows the debounced-level update or the tick that caused it, and a clear
// pulse is low for exactly one Clock cycle.
// ----------------------------------------------------------------------------
module mode_ctrl_fsm #(
    parameter int                   NUM_MODES       = 4,
    parameter int                   DEBOUNCE_MS     = 25,
    parameter int                   LONG_PRESS_MS   = 1000,
    parameter int                   CAL_HOLD_MS     = 2000,
    parameter logic [NUM_MODES-1:0] CLEAR_MASK      = NUM_MODES'(4'b1001),
    parameter int                   IDLE_TIMEOUT_MS = 30000,
    localparam int                  MW              = $clog2(NUM_MODES + 1)
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 tick_1kHz,
    input  logic                 nMode,
    input  logic                 nStart,
    output logic [MW-1:0]        display_mode,
    output logic                 in_calib,
    output logic [NUM_MODES-1:0] nClear
);

    localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_MS - 1);
    localparam logic [15:0]   LP_LAST   = 16'(LONG_PRESS_MS - 1);
    localparam logic [15:0]   CH_LAST   = 16'(CAL_HOLD_MS - 1);
    localparam logic [15:0]   CH_SAT    = 16'(CAL_HOLD_MS);
    localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);
    localparam logic [MW-1:0] CAL_IDX   = MW'(NUM_MODES);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_CALIB  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers (idle value 1 = button released)
    // ------------------------------------------------------------------
    logic mode_meta, mode_sync;
    logic start_meta, start_sync;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mode_meta  <= 1'b1;
            mode_sync  <= 1'b1;
            start_meta <= 1'b1;
            start_sync <= 1'b1;
        end else begin
            mode_meta  <= nMode;
            mode_sync  <= mode_meta;
            start_meta <= nStart;
            start_sync <= start_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: a level only moves after DEBOUNCE_MS consecutive ticks on
    // which the synchronised value disagrees with it.
    // ------------------------------------------------------------------
    logic       mode_s, start_s;
    logic [7:0] mode_db_cnt, start_db_cnt;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mode_s       <= 1'b1;
            start_s      <= 1'b1;
            mode_db_cnt  <= '0;
            start_db_cnt <= '0;
        end else if (tick_1kHz) begin
            if (mode_sync == mode_s) begin
                mode_db_cnt <= '0;
            end else if (mode_db_cnt == DB_LAST) begin
                mode_s      <= mode_sync;
                mode_db_cnt <= '0;
            end else begin
                mode_db_cnt <= mode_db_cnt + 8'd1;
            end

            if (start_sync == start_s) begin
                start_db_cnt <= '0;
            end else if (start_db_cnt == DB_LAST) begin
                start_s      <= start_sync;
                start_db_cnt <= '0;
            end else begin
                start_db_cnt <= start_db_cnt + 8'd1;
            end
        end
    end

    // Registered copy of the mode level for falling-edge detection.
    logic mode_s_d;
    logic mode_fall;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mode_s_d <= 1'b1;
        end else begin
            mode_s_d <= mode_s;
        end
    end

    assign mode_fall = mode_s_d & ~mode_s;

    // ------------------------------------------------------------------
    // Combo hold counter: saturates at CAL_HOLD_MS so calibration is entered
    // once per hold; the reach strobe only fires on the step to saturation.
    // ------------------------------------------------------------------
    logic        both_low;
    logic [15:0] combo_cnt;
    logic        combo_reach;

    assign both_low    = ~mode_s & ~start_s;
    assign combo_reach = tick_1kHz & both_low & (combo_cnt == CH_LAST);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            combo_cnt <= '0;
        end else if (!both_low) begin
            combo_cnt <= '0;
        end else if (tick_1kHz && (combo_cnt != CH_SAT)) begin
            combo_cnt <= combo_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM state registers
    // ------------------------------------------------------------------
    state_t          state, state_next;
    logic [MW-1:0]   idx, idx_next;
    logic            start_rel, start_rel_next;  // nStart released since CALIB entry
    logic            clear_fire;
    logic            state_change;
    logic            idle_reach;

    // Long-press bookkeeping
    logic [15:0]     start_cnt;
    logic            start_lock;   // fired or aborted; cleared only by start release
    logic            clear_ok;
    logic            clear_reach;
    logic [NUM_MODES-1:0] nclear_next;

    // CLEAR_MASK lookup for the current mode index.
    always_comb begin
        clear_ok = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (idx == MW'(i)) begin
                clear_ok = CLEAR_MASK[i];
            end
        end
    end

    assign clear_reach = tick_1kHz & ~start_s & mode_s & ~start_lock & clear_ok &
                         (state == ST_NORMAL) & (start_cnt == LP_LAST);

    // ------------------------------------------------------------------
    // Optional inactivity return
    // ------------------------------------------------------------------
`ifdef AUTO_RETURN_EN
    localparam int            IW        = $clog2(IDLE_TIMEOUT_MS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_MS - 1);

    logic          start_s_d;
    logic          level_change;
    logic          at_home;
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            start_s_d <= 1'b1;
        end else begin
            start_s_d <= start_s;
        end
    end

    assign level_change = (mode_s != mode_s_d) | (start_s != start_s_d);
    assign at_home      = (state == ST_NORMAL) && (idx == '0);
    assign idle_reach   = tick_1kHz & ~at_home & ~level_change & (idle_cnt == IDLE_LAST);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            idle_cnt <= '0;
        end else if (level_change || state_change || at_home) begin
            idle_cnt <= '0;
        end else if (tick_1kHz) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic idle_unused;

    assign idle_reach  = 1'b0;
    assign idle_unused = (IDLE_TIMEOUT_MS != 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic. Priority in NORMAL: calibration entry, then mode
    // advance, then inactivity return, then clear. A clear can never coincide
    // with a state change, so the pulse always belongs to the current mode.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        start_rel_next = start_rel;
        clear_fire     = 1'b0;

        case (state)
            ST_NORMAL: begin
                if (combo_reach) begin
                    state_next     = ST_CALIB;
                    idx_next       = '0;
                    start_rel_next = 1'b0;
                end else if (mode_fall && start_s) begin
                    idx_next = (idx == LAST_MODE) ? '0 : idx + MW'(1);
                end else if (idle_reach) begin
                    idx_next = '0;
                end else if (clear_reach) begin
                    clear_fire = 1'b1;
                end
            end

            ST_CALIB: begin
                if (start_s) begin
                    start_rel_next = 1'b1;
                end
                // A mode edge only leaves once the entry hold has been let go;
                // nMode is necessarily released just before its own falling edge.
                if (mode_fall && (start_rel || start_s)) begin
                    state_next = ST_NORMAL;
                    idx_next   = '0;
                end else if (idle_reach) begin
                    state_next = ST_NORMAL;
                    idx_next   = '0;
                end
            end

            default: begin
                state_next = ST_NORMAL;
                idx_next   = '0;
            end
        endcase
    end

    assign state_change = (state_next != state) | (idx_next != idx);

    always_comb begin
        nclear_next = '1;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (clear_fire && (idx == MW'(i))) begin
                nclear_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state        <= ST_NORMAL;
            idx          <= '0;
            start_rel    <= 1'b0;
            display_mode <= '0;
            in_calib     <= 1'b0;
            nClear       <= '1;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            start_rel    <= start_rel_next;
            display_mode <= (state_next == ST_CALIB) ? CAL_IDX : idx_next;
            in_calib     <= (state_next == ST_CALIB);
            nClear       <= nclear_next;
        end
    end

    // ------------------------------------------------------------------
    // Long-press counter. Pressing nMode during the hold locks it out until
    // nStart is released, exactly like a fired press.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            start_cnt  <= '0;
            start_lock <= 1'b0;
        end else if (start_s) begin
            start_cnt  <= '0;
            start_lock <= 1'b0;
        end else if (!mode_s) begin
            start_cnt  <= '0;
            start_lock <= 1'b1;
        end else if (clear_fire) begin
            start_cnt  <= '0;
            start_lock <= 1'b1;
        end else if (state_change) begin
            start_cnt  <= '0;
        end else if (tick_1kHz && clear_ok && !start_lock && (state == ST_NORMAL)) begin
            start_cnt  <= start_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mode_ctrl_fsm.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_mode_ctrl_fsm
//
// Directed bench for mode_ctrl_fsm with default parameters. The driver pushes
// the expected output word {display_mode, in_calib, nClear} for every output
// change it provokes; a monitor pops and compares whenever the outputs change.
// tick_1kHz is compressed to one pulse every 3 Clock cycles.
// ----------------------------------------------------------------------------
module tb_mode_ctrl_fsm;

    localparam logic [3:0] NC_IDLE = 4'b1111;

    logic       Clock     = 1'b0;
    logic       nReset    = 1'b0;
    logic       tick_1kHz = 1'b0;
    logic       nMode     = 1'b1;
    logic       nStart    = 1'b1;
    logic [2:0] display_mode;
    logic       in_calib;
    logic [3:0] nClear;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    bit         mon_en      = 1'b0;

    mode_ctrl_fsm dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .tick_1kHz    (tick_1kHz),
        .nMode        (nMode),
        .nStart       (nStart),
        .display_mode (display_mode),
        .in_calib     (in_calib),
        .nClear       (nClear)
    );

    // ---------------- clock / tick ----------------
    initial begin
        forever #5 Clock = ~Clock;
    end

    initial begin
        forever begin
            repeat (2) @(negedge Clock);
            tick_1kHz = 1'b1;
            @(negedge Clock);
            tick_1kHz = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] pack(input logic [2:0] m, input logic c, input logic [3:0] n);
        return {m, c, n};
    endfunction

    // Returns 1 ns after the n-th tick edge from now.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            while (tick_1kHz !== 1'b1) @(posedge Clock);
        end
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] m, input logic c, input logic [3:0] n);
        exp_q.push_back(pack(m, c, n));
    endtask

    task automatic press_mode(input logic [2:0] next_mode);
        expect_ev(next_mode, 1'b0, NC_IDLE);
        nMode = 1'b0;
        wait_ticks(30);
        nMode = 1'b1;
        wait_ticks(30);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        logic [7:0] exp;
        int         low_w;
        wait (mon_en);
        @(negedge Clock);
        prev  = {display_mode, in_calib, nClear};
        low_w = 0;
        forever begin
            @(negedge Clock);
            cur = {display_mode, in_calib, nClear};
            if (nClear != NC_IDLE) begin
                low_w++;
            end else if (low_w != 0) begin
                vectors++;
                if (low_w != 1) begin
                    miscompares++;
                    $display("FAIL clear_width: pulse low %0d cycles, required 1", low_w);
                end
                low_w = 0;
            end
            if (cur != prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got mode=%0d calib=%0b nClear=%b, required no change",
                             cur[7:5], cur[4], cur[3:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur != exp) begin
                        miscompares++;
                        $display("FAIL event: got mode=%0d calib=%0b nClear=%b, required mode=%0d calib=%0b nClear=%b",
                                 cur[7:5], cur[4], cur[3:0], exp[7:5], exp[4], exp[3:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] got;
        nReset = 1'b0;
        repeat (5) @(posedge Clock);
        #1 nReset = 1'b1;
        @(negedge Clock);
        got = {display_mode, in_calib, nClear};
        vectors++;
        if (got !== pack(3'd0, 1'b0, NC_IDLE)) begin
            miscompares++;
            $display("FAIL reset_state: got %b, required %b", got, pack(3'd0, 1'b0, NC_IDLE));
        end
        mon_en = 1'b1;
        wait_ticks(5);

        // 1: debounce threshold, 24 ticks rejected, 25 accepted
        nMode = 1'b0;
        wait_ticks(24);
        nMode = 1'b1;
        wait_ticks(30);
        expect_ev(3'd1, 1'b0, NC_IDLE);
        nMode = 1'b0;
        wait_ticks(25);
        nMode = 1'b1;
        wait_ticks(30);

        // 2: wrap-around through all modes
        press_mode(3'd2);
        press_mode(3'd3);
        press_mode(3'd0);
        press_mode(3'd1);
        press_mode(3'd2);
        press_mode(3'd3);
        press_mode(3'd0);

        // 3: long press in mode 0 fires once; mode 1 has no clear
        expect_ev(3'd0, 1'b0, 4'b1110);
        expect_ev(3'd0, 1'b0, NC_IDLE);
        nStart = 1'b0;
        wait_ticks(3000);
        nStart = 1'b1;
        wait_ticks(30);
        press_mode(3'd1);
        nStart = 1'b0;
        wait_ticks(1100);
        nStart = 1'b1;
        wait_ticks(30);

        // 4: combo hold one tick short, then full hold into calibration
        nMode  = 1'b0;
        nStart = 1'b0;
        wait_ticks(1999);
        nMode  = 1'b1;
        nStart = 1'b1;
        wait_ticks(30);
        expect_ev(3'd4, 1'b1, NC_IDLE);
        nMode  = 1'b0;
        nStart = 1'b0;
        wait_ticks(2030);
        nMode = 1'b1;          // nStart still held: next mode press is ignored
        wait_ticks(30);
        nMode = 1'b0;
        wait_ticks(30);
        nMode = 1'b1;
        wait_ticks(30);
        nStart = 1'b1;
        wait_ticks(30);
        press_mode(3'd0);

        // 5: mode press during a start hold aborts the clear in mode 3
        press_mode(3'd1);
        press_mode(3'd2);
        press_mode(3'd3);
        nStart = 1'b0;
        wait_ticks(500);
        nMode = 1'b0;
        wait_ticks(40);
        nMode = 1'b1;
        wait_ticks(2000);
        nStart = 1'b1;
        wait_ticks(30);

        // 6: reset during a hold discards progress
        nStart = 1'b0;
        wait_ticks(900);
        expect_ev(3'd0, 1'b0, NC_IDLE);
        nReset = 1'b0;
        repeat (3) @(posedge Clock);
        #1 nReset = 1'b1;
        wait_ticks(200);
        nStart = 1'b1;
        wait_ticks(30);
        expect_ev(3'd0, 1'b0, 4'b1110);
        expect_ev(3'd0, 1'b0, NC_IDLE);
        nStart = 1'b0;
        wait_ticks(1030);
        nStart = 1'b1;
        wait_ticks(40);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events: %0d outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
